// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler driving the select of a shared 16:1 mux.
// Grants are held until the owner releases or MAX_HOLD cycles elapse.
module mux16_rr_scheduler #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        valid,
    output logic        timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [3:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [15:0] rot;
    logic        found;
    logic [3:0]  winner;
    logic        expired;
    logic        released;

    // ptr always equals sel+1 while in GRANT, so one search serves both
    // states and leaves an expiring owner at the end of the scan order.
    always_comb begin
        rot    = (req >> ptr) | (req << (5'd16 - {1'b0, ptr}));
        found  = |req;
        winner = ptr;
        for (int unsigned i = 0; i < 16; i++) begin
            if (rot[15-i]) winner = ptr + 4'(15 - i);
        end
    end

    assign expired  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign released = !req[sel] || expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            gnt      <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        sel      <= winner;
                        gnt      <= 16'd1 << winner;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                        ptr      <= winner + 4'd1;
                    end
                end
                GRANT: begin
                    if (!released) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        timeout <= expired && req[sel];
                        if (found) begin
                            sel      <= winner;
                            gnt      <= 16'd1 << winner;
                            valid    <= 1'b1;
                            hold_cnt <= '0;
                            ptr      <= winner + 4'd1;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench for mux16_rr_scheduler: directed vectors, corner
// sequences, and randomized traffic against a queue-free reference model.
module tb_mux16_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [3:0]  sel_a, sel_b;
    logic [15:0] gnt_a, gnt_b;
    logic        valid_a, valid_b, timeout_a, timeout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux16_rr_scheduler #(.MAX_HOLD(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .sel(sel_a), .gnt(gnt_a), .valid(valid_a), .timeout(timeout_a)
    );

    mux16_rr_scheduler #(.MAX_HOLD(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .sel(sel_b), .gnt(gnt_b), .valid(valid_b), .timeout(timeout_b)
    );

    // Reference: owner index (-1 = none), cycles owned so far, search start.
    typedef struct {
        int owner;
        int held;
        int ptr;
        bit tmo;
    } model_t;

    model_t ma, mb;

    typedef struct {
        logic [15:0] req;
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        valid;
        logic        tmo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1;
        m.held  = 0;
        m.ptr   = 0;
        m.tmo   = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m_in, input logic [15:0] r, input int mh);
        model_t m;
        bit     search;
        int     w;
        m      = m_in;
        m.tmo  = 1'b0;
        search = 1'b0;
        if (m.owner < 0) begin
            search = 1'b1;
        end else if (!r[m.owner] || m.held == mh) begin
            m.tmo  = r[m.owner] && (m.held == mh);
            search = 1'b1;
        end else begin
            m.held++;
        end
        if (search) begin
            w = -1;
            for (int k = 0; k < 16; k++) begin
                if (w < 0 && r[(m.ptr + k) % 16]) w = (m.ptr + k) % 16;
            end
            m.owner = w;
            if (w >= 0) begin
                m.held = 1;
                m.ptr  = (w + 1) % 16;
            end
        end
        return m;
    endfunction

    task automatic cycle(input logic [15:0] ra, input logic [15:0] rb);
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        ma = model_step(ma, ra, 8);
        mb = model_step(mb, rb, 1);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        ma = model_reset();
        mb = model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_model(input string tag, input model_t m, input logic [15:0] g,
                               input logic [3:0] s, input logic v, input logic t);
        logic [15:0] eg;
        eg = (m.owner >= 0) ? (16'd1 << m.owner) : 16'd0;
        check({tag, "_gnt"}, 32'(g), 32'(eg));
        check({tag, "_valid"}, 32'(v), 32'(m.owner >= 0));
        check({tag, "_timeout"}, 32'(t), 32'(m.tmo));
        if (m.owner >= 0) check({tag, "_sel"}, 32'(s), 32'(m.owner));
    endtask

    initial begin
        vec_t        vecs[7];
        int          rot_seq[3];
        logic [15:0] ra, rb;

        vecs[0] = '{16'h0001, 16'h0001, 4'd0,  1'b1, 1'b0};
        vecs[1] = '{16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[2] = '{16'h0420, 16'h0020, 4'd5,  1'b1, 1'b0};
        vecs[3] = '{16'h0420, 16'h0020, 4'd5,  1'b1, 1'b0};
        vecs[4] = '{16'h0420, 16'h0020, 4'd5,  1'b1, 1'b0};
        vecs[5] = '{16'h0400, 16'h0400, 4'd10, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0};
        rot_seq = '{0, 2, 15};
        ma = model_reset();
        mb = model_reset();

        // Reset held with a pending request
        req_a = 16'h0001;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt_a), 32'h0);
        check("rst_sel", 32'(sel_a), 32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_timeout", 32'(timeout_a), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_gnt", 32'(gnt_a), 32'h0001);
        check("first_edge_sel", 32'(sel_a), 32'h0);

        foreach (vecs[i]) begin
            cycle(vecs[i].req, 16'h0);
            check($sformatf("vec%0d_gnt", i), 32'(gnt_a), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_valid", i), 32'(valid_a), 32'(vecs[i].valid));
            check($sformatf("vec%0d_timeout", i), 32'(timeout_a), 32'(vecs[i].tmo));
            if (vecs[i].valid) check($sformatf("vec%0d_sel", i), 32'(sel_a), 32'(vecs[i].sel));
        end

        // MAX_HOLD=1 rotation on dut_b
        for (int c = 0; c < 9; c++) begin
            cycle(16'h0, 16'h8005);
            check($sformatf("rot%0d_sel", c), 32'(sel_b), 32'(rot_seq[c % 3]));
            check($sformatf("rot%0d_timeout", c), 32'(timeout_b), 32'(c > 0));
        end

        // Hold expiry alternating between 2 and 13
        do_reset();
        for (int c = 0; c < 24; c++) begin
            cycle(16'h2004, 16'h0);
            check($sformatf("exp%0d_sel", c), 32'(sel_a), 32'(((c / 8) % 2) ? 13 : 2));
            check($sformatf("exp%0d_timeout", c), 32'(timeout_a), 32'(c > 0 && c % 8 == 0));
        end

        // Lone requester 15 re-granted to itself, then wraps to 0
        do_reset();
        for (int c = 0; c < 16; c++) begin
            cycle(16'h8000, 16'h0);
            check($sformatf("self%0d_gnt", c), 32'(gnt_a), 32'h8000);
            check($sformatf("self%0d_timeout", c), 32'(timeout_a), 32'(c == 8));
        end
        cycle(16'h8001, 16'h0);
        check("wrap_sel", 32'(sel_a), 32'h0);
        check("wrap_timeout", 32'(timeout_a), 32'h1);
        cycle(16'h8001, 16'h0);
        check("wrap_hold_timeout", 32'(timeout_a), 32'h0);

        // Asynchronous reset between edges while 13 owns the mux
        do_reset();
        cycle(16'h2000, 16'h0);
        check("async_pre_sel", 32'(sel_a), 32'd13);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt_a), 32'h0);
        check("async_valid", 32'(valid_a), 32'h0);
        check("async_sel", 32'(sel_a), 32'h0);
        req_a = 16'hFFFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("async_restart_sel", 32'(sel_a), 32'h0);
        check("async_restart_gnt", 32'(gnt_a), 32'h0001);

        // Randomized traffic with persistent, slowly toggling request bits
        do_reset();
        ra = '0;
        rb = '0;
        for (int c = 0; c < 3000; c++) begin
            ra ^= 16'($urandom & $urandom & $urandom);
            rb ^= 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 39) == 0) ra = '0;
            if ($urandom_range(0, 39) == 0) rb = '0;
            cycle(ra, rb);
            check_model("rand_a", ma, gnt_a, sel_a, valid_a, timeout_a);
            check_model("rand_b", mb, gnt_b, sel_b, valid_b, timeout_b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux16_rr_scheduler.md
# mux16_rr_scheduler

Round-robin scheduler that shares one 16:1 multiplexer among 16 requesters. Each cycle it arbitrates among the active request lines and drives the mux select `sel[3:0]` and a one-hot grant vector. It holds each grant until the owner releases it or a hold-time limit expires. It sits directly in front of the 16:1 mux: `sel` connects to the mux select, and `gnt` returns to the requesters.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may own the mux (legal range 1..255).
- `CNT_W`, default 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `req`, in, 16: request lines; `req[i]` high means requester i wants the mux.
- `sel`, out, 4: mux select, equal to the index of the current owner.
- `gnt`, out, 16: one-hot grant; all zero when no owner.
- `valid`, out, 1: high while a grant is active; equals `|gnt`.
- `timeout`, out, 1: one-cycle pulse marking that the current grant was revoked by `MAX_HOLD` expiry.

## Operation
- FSM with two states:
  - IDLE: no owner.
  - GRANT: owner held in the `sel` register.
- Outputs `sel`, `gnt`, `valid`, `timeout` are registered. Internal state: `ptr[3:0]`, the search start index, and `hold_cnt[CNT_W-1:0]`.
- Arbitration (combinational):
  - Winner = first i with `req[i]`=1, scanning `ptr`, `ptr`+1, …, `ptr`+15, all mod 16 (wraps 15→0).
  - `ptr` updates to (winner+1) mod 16 on every new grant.
- IDLE:
  - If `req`≠0: next state GRANT, `sel`=winner, `gnt`=1<<winner, `valid`=1, `hold_cnt`=0.
  - Otherwise stay in IDLE with outputs unchanged (zero).
- GRANT, release condition: `req[sel]`=0 (voluntary release) OR `hold_cnt`=MAX_HOLD-1 (expiry).
- GRANT, no release: stay; `hold_cnt` increments by 1.
- GRANT, release:
  - Re-arbitrate in the same cycle using the updated pointer (`sel`+1).
  - On expiry the current owner remains eligible, but it is searched last.
  - If a winner exists, grant it directly (back-to-back, no idle cycle) and clear `hold_cnt`.
  - If no winner exists, go to IDLE: `gnt`=0, `valid`=0. `sel` keeps its last value; it is don't-care while `valid`=0.
- `timeout` is set high for exactly the cycle after an expiry-triggered release, regardless of who wins next. It is low otherwise.
- A request that drops before being granted is simply not considered. No request is latched.
- Invariant: at most one bit of `gnt` is set, and `gnt`[`sel`]=1 whenever `valid`=1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - State IDLE.
  - `sel`=0, `gnt`=0, `valid`=0, `timeout`=0.
  - `ptr`=0, `hold_cnt`=0.
- Reset asserted mid-grant: all outputs clear immediately, without waiting for a clock edge. After deassert, arbitration restarts from index 0.
- Grant latency: a `req` sampled at edge k produces `gnt`/`sel` valid after edge k. There is one cycle from `req` rising to `gnt` rising.
- Release latency: an owner dropping `req` before edge k loses `gnt` after edge k. The next owner's `gnt` rises at that same edge.
- Maximum ownership: exactly `MAX_HOLD` cycles of `valid`, counting the grant cycle, while other requesters are pending.
- `MAX_HOLD`=1 degenerates to pure per-cycle round-robin among the active requesters.
- Starvation bound: a requester held continuously high is granted within 15×`MAX_HOLD`+1 cycles.

## Test plan
- Reset and single request:
  - During reset, `req`=16'h0001 → `gnt`=0, `sel`=0, `valid`=0.
  - After `rst_n` rises, first edge → `gnt`=16'h0001, `sel`=0.
  - Drop `req` → next edge `gnt`=0, `valid`=0.
- Round-robin rotation:
  - `req`=16'h8005 held constant, `MAX_HOLD`=1 → `sel` sequence 0, 2, 15, 0, 2, …
  - `timeout` pulses on every handover.
- Hold expiry:
  - `req`=16'h2004, `MAX_HOLD`=8 → `sel`=2 for exactly 8 cycles.
  - Then `timeout`=1 for one cycle with `sel`=13 for the next 8 cycles, then back to 2.
- Voluntary back-to-back:
  - Owner 5 (`req`=16'h0420) drops bit 5 after 3 cycles → next edge `gnt`=16'h0400, `sel`=10, no idle cycle, `timeout`=0.
- Wrap-around and re-grant to self:
  - Owner 15 with `req`=16'h8000 only, expires at `MAX_HOLD` → re-granted to 15 with `timeout` pulse and `hold_cnt` restart.
  - Then `req`=16'h0001 added → after the next expiry, `sel`=0.
- Asynchronous reset mid-grant:
  - Assert `rst_n`=0 between edges while `sel`=13 → `gnt`, `valid`, `sel` go to 0 before the next edge.
  - After release with `req`=16'hFFFF → `sel`=0 first.
